// File: rtl/biu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biu_pkg : shared state/owner encodings for the bus interface unit
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package biu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage : biu_pkg
`default_nettype wire

// File: rtl/biu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biu : arbitrates IFU/LSU requests onto a single-outstanding memory bus
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module biu
   import biu_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ifu2biu_req_vld,
   output logic            ifu2biu_req_rdy,
   input  logic [AW-1:0]   ifu2biu_req_pc,
   output logic            biu2ifu_rsp_vld,
   input  logic            biu2ifu_rsp_rdy,
   output logic [DW-1:0]   biu2ifu_rsp_inst,
   input  logic            lsu2biu_req_vld,
   output logic            lsu2biu_req_rdy,
   input  logic [AW-1:0]   lsu2biu_req_addr,
   input  logic            lsu2biu_req_wen,
   input  logic [DW-1:0]   lsu2biu_req_wdata,
   input  logic [DW/8-1:0] lsu2biu_req_wstrb,
   output logic            biu2lsu_rsp_vld,
   input  logic            biu2lsu_rsp_rdy,
   output logic [DW-1:0]   biu2lsu_rsp_rdata,
   output logic            biu2mem_req_vld,
   input  logic            biu2mem_req_rdy,
   output logic [AW-1:0]   biu2mem_req_addr,
   output logic            biu2mem_req_wen,
   output logic [DW-1:0]   biu2mem_req_wdata,
   output logic [DW/8-1:0] biu2mem_req_wstrb,
   input  logic            mem2biu_rsp_vld,
   output logic            mem2biu_rsp_rdy,
   input  logic [DW-1:0]   mem2biu_rsp_rdata
);

   localparam int SW = DW / 8;

   state_t          r_state;
   state_t          w_next_state;
   owner_t          r_owner;
   logic [AW-1:0]   r_addr;
   logic            r_wen;
   logic [DW-1:0]   r_wdata;
   logic [SW-1:0]   r_wstrb;

   logic            w_accept_lsu;
   logic            w_accept_ifu;

   // LSU always wins in IDLE; an IFU request is only taken when the LSU is quiet
   assign w_accept_lsu = (r_state == IDLE) && lsu2biu_req_vld;
   assign w_accept_ifu = (r_state == IDLE) && ifu2biu_req_vld && !lsu2biu_req_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (lsu2biu_req_vld || ifu2biu_req_vld) w_next_state = REQ;
         REQ:  if (biu2mem_req_rdy)                    w_next_state = RSP;
         RSP:  if (mem2biu_rsp_vld && mem2biu_rsp_rdy) w_next_state = IDLE;
         default:                                      w_next_state = IDLE;
      endcase
   end

   always_comb begin
      ifu2biu_req_rdy   = 1'b0;
      lsu2biu_req_rdy   = 1'b0;
      biu2mem_req_vld   = 1'b0;
      biu2ifu_rsp_vld   = 1'b0;
      biu2ifu_rsp_inst  = '0;
      biu2lsu_rsp_vld   = 1'b0;
      biu2lsu_rsp_rdata = '0;
      mem2biu_rsp_rdy   = 1'b0;
      case (r_state)
         IDLE: begin
            lsu2biu_req_rdy = 1'b1;
            ifu2biu_req_rdy = !lsu2biu_req_vld;
         end
         REQ: begin
            biu2mem_req_vld = 1'b1;
         end
         RSP: begin
            if (r_owner == OWN_LSU) begin
               biu2lsu_rsp_vld   = mem2biu_rsp_vld;
               biu2lsu_rsp_rdata = mem2biu_rsp_rdata;
               mem2biu_rsp_rdy   = biu2lsu_rsp_rdy;
            end else begin
               biu2ifu_rsp_vld   = mem2biu_rsp_vld;
               biu2ifu_rsp_inst  = mem2biu_rsp_rdata;
               mem2biu_rsp_rdy   = biu2ifu_rsp_rdy;
            end
         end
         default: begin
         end
      endcase
   end

   // Payload is only loaded on acceptance, so it stays stable for the whole transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= OWN_IFU;
         r_addr  <= '0;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_accept_lsu) begin
         r_owner <= OWN_LSU;
         r_addr  <= lsu2biu_req_addr;
         r_wen   <= lsu2biu_req_wen;
         r_wdata <= lsu2biu_req_wdata;
         r_wstrb <= lsu2biu_req_wstrb;
      end else if (w_accept_ifu) begin
         r_owner <= OWN_IFU;
         r_addr  <= ifu2biu_req_pc;
         r_wen   <= 1'b0;
         r_wdata <= '0;
         r_wstrb <= '1;
      end
   end

   assign biu2mem_req_addr  = r_addr;
   assign biu2mem_req_wen   = r_wen;
   assign biu2mem_req_wdata = r_wdata;
   assign biu2mem_req_wstrb = r_wstrb;

endmodule : biu
`default_nettype wire

// File: tb/tb_biu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_biu : directed vector bench for biu (table-driven plus corner sequences)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_biu;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic            ifu2biu_req_vld;
   logic            ifu2biu_req_rdy;
   logic [AW-1:0]   ifu2biu_req_pc;
   logic            biu2ifu_rsp_vld;
   logic            biu2ifu_rsp_rdy;
   logic [DW-1:0]   biu2ifu_rsp_inst;
   logic            lsu2biu_req_vld;
   logic            lsu2biu_req_rdy;
   logic [AW-1:0]   lsu2biu_req_addr;
   logic            lsu2biu_req_wen;
   logic [DW-1:0]   lsu2biu_req_wdata;
   logic [DW/8-1:0] lsu2biu_req_wstrb;
   logic            biu2lsu_rsp_vld;
   logic            biu2lsu_rsp_rdy;
   logic [DW-1:0]   biu2lsu_rsp_rdata;
   logic            biu2mem_req_vld;
   logic            biu2mem_req_rdy;
   logic [AW-1:0]   biu2mem_req_addr;
   logic            biu2mem_req_wen;
   logic [DW-1:0]   biu2mem_req_wdata;
   logic [DW/8-1:0] biu2mem_req_wstrb;
   logic            mem2biu_rsp_vld;
   logic            mem2biu_rsp_rdy;
   logic [DW-1:0]   mem2biu_rsp_rdata;

   int checks = 0;
   int errors = 0;

   biu #(.AW(AW), .DW(DW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ifu2biu_req_vld   (ifu2biu_req_vld),
      .ifu2biu_req_rdy   (ifu2biu_req_rdy),
      .ifu2biu_req_pc    (ifu2biu_req_pc),
      .biu2ifu_rsp_vld   (biu2ifu_rsp_vld),
      .biu2ifu_rsp_rdy   (biu2ifu_rsp_rdy),
      .biu2ifu_rsp_inst  (biu2ifu_rsp_inst),
      .lsu2biu_req_vld   (lsu2biu_req_vld),
      .lsu2biu_req_rdy   (lsu2biu_req_rdy),
      .lsu2biu_req_addr  (lsu2biu_req_addr),
      .lsu2biu_req_wen   (lsu2biu_req_wen),
      .lsu2biu_req_wdata (lsu2biu_req_wdata),
      .lsu2biu_req_wstrb (lsu2biu_req_wstrb),
      .biu2lsu_rsp_vld   (biu2lsu_rsp_vld),
      .biu2lsu_rsp_rdy   (biu2lsu_rsp_rdy),
      .biu2lsu_rsp_rdata (biu2lsu_rsp_rdata),
      .biu2mem_req_vld   (biu2mem_req_vld),
      .biu2mem_req_rdy   (biu2mem_req_rdy),
      .biu2mem_req_addr  (biu2mem_req_addr),
      .biu2mem_req_wen   (biu2mem_req_wen),
      .biu2mem_req_wdata (biu2mem_req_wdata),
      .biu2mem_req_wstrb (biu2mem_req_wstrb),
      .mem2biu_rsp_vld   (mem2biu_rsp_vld),
      .mem2biu_rsp_rdy   (mem2biu_rsp_rdy),
      .mem2biu_rsp_rdata (mem2biu_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_lsu;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ifu2biu_req_vld   = 1'b0;
      ifu2biu_req_pc    = '0;
      lsu2biu_req_vld   = 1'b0;
      lsu2biu_req_addr  = '0;
      lsu2biu_req_wen   = 1'b0;
      lsu2biu_req_wdata = '0;
      lsu2biu_req_wstrb = '0;
      biu2ifu_rsp_rdy   = 1'b0;
      biu2lsu_rsp_rdy   = 1'b0;
      biu2mem_req_rdy   = 1'b0;
      mem2biu_rsp_vld   = 1'b0;
      mem2biu_rsp_rdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Brings an accepted request in REQ through a zero-wait bus and response
   task automatic finish_txn(input logic is_lsu, input logic [31:0] rdata, input logic chk_data, input string tag);
      biu2mem_req_rdy = 1'b1;
      step();
      biu2mem_req_rdy   = 1'b0;
      mem2biu_rsp_vld   = 1'b1;
      mem2biu_rsp_rdata = rdata;
      biu2ifu_rsp_rdy   = 1'b1;
      biu2lsu_rsp_rdy   = 1'b1;
      #1;
      chk({tag, " bus vld drops in RSP"}, 64'(biu2mem_req_vld), 64'd0);
      chk({tag, " ifu rsp vld"}, 64'(biu2ifu_rsp_vld), 64'(!is_lsu));
      chk({tag, " lsu rsp vld"}, 64'(biu2lsu_rsp_vld), 64'(is_lsu));
      chk({tag, " mem rsp rdy"}, 64'(mem2biu_rsp_rdy), 64'd1);
      if (chk_data) begin
         if (is_lsu) chk({tag, " lsu rdata"}, 64'(biu2lsu_rsp_rdata), 64'(rdata));
         else        chk({tag, " ifu inst"}, 64'(biu2ifu_rsp_inst), 64'(rdata));
      end
      step();
      mem2biu_rsp_vld = 1'b0;
      biu2ifu_rsp_rdy = 1'b0;
      biu2lsu_rsp_rdy = 1'b0;
      #1;
      chk({tag, " back in IDLE lsu rdy"}, 64'(lsu2biu_req_rdy), 64'd1);
      chk({tag, " no rsp after done"}, 64'({biu2ifu_rsp_vld, biu2lsu_rsp_vld}), 64'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0004, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 32'h0, 4'hF};
      vecs[1] = '{1'b1, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h5555_AAAA, 1'b1, 32'hDEAD_BEEF, 4'b0011};
      vecs[2] = '{1'b1, 32'h0000_0104, 1'b0, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h1234_5678, 4'hF};
      vecs[3] = '{1'b0, 32'h0000_0003, 1'b0, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 32'h0, 4'hF};
      vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0BAD_F00D, 4'b1000, 32'h0, 1'b1, 32'h0BAD_F00D, 4'b1000};

      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("reset bus vld", 64'(biu2mem_req_vld), 64'd0);
      chk("reset rsp vlds", 64'({biu2ifu_rsp_vld, biu2lsu_rsp_vld}), 64'd0);
      chk("reset mem rsp rdy", 64'(mem2biu_rsp_rdy), 64'd0);
      chk("reset bus addr", 64'(biu2mem_req_addr), 64'd0);
      chk("reset bus strb/wen/data", 64'({biu2mem_req_wstrb, biu2mem_req_wen, biu2mem_req_wdata}), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("post-reset lsu rdy", 64'(lsu2biu_req_rdy), 64'd1);
      chk("post-reset ifu rdy", 64'(ifu2biu_req_rdy), 64'd1);

      // Stray bus response in IDLE must be ignored
      mem2biu_rsp_vld = 1'b1;
      biu2ifu_rsp_rdy = 1'b1;
      #1;
      chk("stray rsp mem rdy", 64'(mem2biu_rsp_rdy), 64'd0);
      chk("stray rsp not forwarded", 64'({biu2ifu_rsp_vld, biu2lsu_rsp_vld}), 64'd0);
      step();
      idle_inputs();
      #1;

      for (int i = 0; i < 5; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         if (vecs[i].is_lsu) begin
            lsu2biu_req_vld   = 1'b1;
            lsu2biu_req_addr  = vecs[i].addr;
            lsu2biu_req_wen   = vecs[i].wen;
            lsu2biu_req_wdata = vecs[i].wdata;
            lsu2biu_req_wstrb = vecs[i].wstrb;
         end else begin
            ifu2biu_req_vld   = 1'b1;
            ifu2biu_req_pc    = vecs[i].addr;
            lsu2biu_req_wdata = 32'hFFFF_FFFF;
            lsu2biu_req_wen   = 1'b1;
         end
         #1;
         chk({tag, " upstream rdy"}, 64'(vecs[i].is_lsu ? lsu2biu_req_rdy : ifu2biu_req_rdy), 64'd1);
         step();
         idle_inputs();
         #1;
         chk({tag, " bus vld"}, 64'(biu2mem_req_vld), 64'd1);
         chk({tag, " bus addr"}, 64'(biu2mem_req_addr), 64'(vecs[i].addr));
         chk({tag, " bus wen"}, 64'(biu2mem_req_wen), 64'(vecs[i].exp_wen));
         chk({tag, " bus wdata"}, 64'(biu2mem_req_wdata), 64'(vecs[i].exp_wdata));
         chk({tag, " bus wstrb"}, 64'(biu2mem_req_wstrb), 64'(vecs[i].exp_wstrb));
         chk({tag, " upstream rdy in REQ"}, 64'({ifu2biu_req_rdy, lsu2biu_req_rdy}), 64'd0);
         finish_txn(vecs[i].is_lsu, vecs[i].rdata, !vecs[i].exp_wen, tag);
      end

      // Contention: LSU first, IFU held pending and served next
      ifu2biu_req_vld  = 1'b1;
      ifu2biu_req_pc   = 32'h0000_0008;
      lsu2biu_req_vld  = 1'b1;
      lsu2biu_req_addr = 32'h0000_0100;
      lsu2biu_req_wen  = 1'b0;
      #1;
      chk("contend ifu rdy", 64'(ifu2biu_req_rdy), 64'd0);
      chk("contend lsu rdy", 64'(lsu2biu_req_rdy), 64'd1);
      step();
      lsu2biu_req_vld = 1'b0;
      #1;
      chk("contend bus addr lsu", 64'(biu2mem_req_addr), 64'h100);
      chk("contend ifu rdy in REQ", 64'(ifu2biu_req_rdy), 64'd0);
      finish_txn(1'b1, 32'h7777_0001, 1'b1, "contend lsu");
      chk("contend ifu rdy in next IDLE", 64'(ifu2biu_req_rdy), 64'd1);
      step();
      ifu2biu_req_vld = 1'b0;
      #1;
      chk("contend bus addr ifu", 64'(biu2mem_req_addr), 64'h8);
      chk("contend bus wen ifu", 64'(biu2mem_req_wen), 64'd0);
      finish_txn(1'b0, 32'h0000_0013, 1'b1, "contend ifu");

      // Backpressure: bus stall 3 cycles, then IFU response stall 2 cycles
      ifu2biu_req_vld = 1'b1;
      ifu2biu_req_pc  = 32'h0000_0040;
      step();
      ifu2biu_req_vld   = 1'b1;
      ifu2biu_req_pc    = 32'h0000_0044;
      lsu2biu_req_vld   = 1'b1;
      lsu2biu_req_addr  = 32'h0000_0300;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d bus vld", c), 64'(biu2mem_req_vld), 64'd1);
         chk($sformatf("stall%0d bus addr", c), 64'(biu2mem_req_addr), 64'h40);
         chk($sformatf("stall%0d bus strb", c), 64'(biu2mem_req_wstrb), 64'hF);
         chk($sformatf("stall%0d upstream rdy", c), 64'({ifu2biu_req_rdy, lsu2biu_req_rdy}), 64'd0);
         step();
      end
      biu2mem_req_rdy = 1'b1;
      step();
      biu2mem_req_rdy   = 1'b0;
      mem2biu_rsp_vld   = 1'b1;
      mem2biu_rsp_rdata = 32'h0040_0093;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("rspstall%0d mem rsp rdy", c), 64'(mem2biu_rsp_rdy), 64'd0);
         chk($sformatf("rspstall%0d ifu vld", c), 64'(biu2ifu_rsp_vld), 64'd1);
         chk($sformatf("rspstall%0d upstream rdy", c), 64'({ifu2biu_req_rdy, lsu2biu_req_rdy}), 64'd0);
         step();
      end
      ifu2biu_req_vld = 1'b0;
      lsu2biu_req_vld = 1'b0;
      biu2ifu_rsp_rdy = 1'b1;
      #1;
      chk("rspstall release mem rdy", 64'(mem2biu_rsp_rdy), 64'd1);
      chk("rspstall inst", 64'(biu2ifu_rsp_inst), 64'h0040_0093);
      step();
      idle_inputs();
      #1;
      chk("after stall idle", 64'(lsu2biu_req_rdy), 64'd1);

      // Reset pulse while in RSP with a live bus response
      ifu2biu_req_vld = 1'b1;
      ifu2biu_req_pc  = 32'h0000_0060;
      step();
      ifu2biu_req_vld = 1'b0;
      biu2mem_req_rdy = 1'b1;
      step();
      biu2mem_req_rdy = 1'b0;
      mem2biu_rsp_vld = 1'b1;
      rst_n           = 1'b0;
      #1;
      chk("rst-in-RSP vlds", 64'({biu2mem_req_vld, biu2ifu_rsp_vld, biu2lsu_rsp_vld, mem2biu_rsp_rdy}), 64'd0);
      step();
      rst_n           = 1'b1;
      biu2ifu_rsp_rdy = 1'b1;
      biu2lsu_rsp_rdy = 1'b1;
      #1;
      chk("post-rst no rsp", 64'({biu2ifu_rsp_vld, biu2lsu_rsp_vld, mem2biu_rsp_rdy}), 64'd0);
      mem2biu_rsp_vld = 1'b0;
      ifu2biu_req_vld = 1'b1;
      ifu2biu_req_pc  = 32'h0000_0080;
      #1;
      chk("post-rst ifu rdy", 64'(ifu2biu_req_rdy), 64'd1);
      step();
      ifu2biu_req_vld = 1'b0;
      #1;
      chk("post-rst bus vld", 64'(biu2mem_req_vld), 64'd1);
      chk("post-rst bus addr", 64'(biu2mem_req_addr), 64'h80);
      finish_txn(1'b0, 32'h0000_0513, 1'b1, "post-rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_biu
`default_nettype wire
